// File: rtl/aes_inv_data_path.sv
// Iterative AES-128 inverse cipher, one round per clock; 11 cycles from accept to o_valid.
// Holds the result with o_ready low until i_ready; i_valid outside IDLE is dropped.
module aes_inv_data_path #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4,
    parameter int NUM_RND  = 10,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [RND_SIZE-1:0] i_cypher_text,
    output logic [CNT_SIZE-1:0] o_key_idx,
    input  logic [RND_SIZE-1:0] i_rnd_key,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [RND_SIZE-1:0] o_plain_text
);

    localparam int NUM_BYTE = RND_SIZE / 8;
    localparam logic [CNT_SIZE-1:0] LAST_IDX  = CNT_SIZE'(NUM_RND);
    localparam logic [CNT_SIZE-1:0] FIRST_CNT = CNT_SIZE'(NUM_RND - 1);

    // Inverse S-box, entry 0 in the top byte; entry b sits at bit {~b, 3'b111}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t                state, state_nxt;
    logic [CNT_SIZE-1:0] rnd_cnt;
    logic [RND_SIZE-1:0] state_reg;
    logic [RND_SIZE-1:0] shf, sub, ark, imc, rnd_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WRD_SIZE-1:0] inv_mix_col(input logic [WRD_SIZE-1:0] col);
        logic [7:0] a [4];
        logic [7:0] x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[WRD_SIZE-1-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r of column c comes from column c-r.
    for (genvar c = 0; c < NUM_BLK; c++) begin : g_shf_col
        for (genvar r = 0; r < 4; r++) begin : g_shf_row
            assign shf[RND_SIZE-1-8*(4*c+r) -: 8] =
                state_reg[RND_SIZE-1-8*(4*((c-r+NUM_BLK)%NUM_BLK)+r) -: 8];
        end
    end

    for (genvar i = 0; i < NUM_BYTE; i++) begin : g_sbox
        logic [7:0] sb_in;
        assign sb_in = shf[RND_SIZE-1-8*i -: 8];
        assign sub[RND_SIZE-1-8*i -: 8] = INV_SBOX[{~sb_in, 3'b111} -: 8];
    end

    assign ark = sub ^ i_rnd_key;

    for (genvar c = 0; c < NUM_BLK; c++) begin : g_imc
        assign imc[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE] =
            inv_mix_col(ark[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE]);
    end

    // Final round drops InvMixColumns.
    assign rnd_out = (rnd_cnt == '0) ? ark : imc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rnd_cnt   <= '0;
            state_reg <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        state_reg <= i_cypher_text ^ i_rnd_key;
                        rnd_cnt   <= FIRST_CNT;
                    end
                end
                S_RUN: begin
                    state_reg <= rnd_out;
                    if (rnd_cnt != '0) rnd_cnt <= rnd_cnt - CNT_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_key_idx = LAST_IDX;
        case (state)
            S_IDLE: begin
                o_ready = !rst;
                if (i_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                o_key_idx = rnd_cnt;
                if (rnd_cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_valid = !rst;
                if (i_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_plain_text = state_reg;

endmodule

// File: tb/tb_aes_inv_data_path.sv
// Bench for aes_inv_data_path: FIPS-197 vectors, backpressure, busy-ignore, abort, random blocks.
// Reference: S-box derived from GF(2^8) inverse + affine map, forward cipher, key expansion.
module tb_aes_inv_data_path;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_cypher_text;
    logic [3:0]   o_key_idx;
    logic [127:0] i_rnd_key;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_plain_text;

    aes_inv_data_path dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_cypher_text (i_cypher_text),
        .o_key_idx     (o_key_idx),
        .i_rnd_key     (i_rnd_key),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_plain_text  (o_plain_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int last_acc = -1;

    logic [7:0]   sb [256];
    logic [127:0] rk [11];

    // Combinational key store read.
    always_comb i_rnd_key = (o_key_idx <= 4'd10) ? rk[o_key_idx] : '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = b;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sb[s[127-8*i -: 8]];
            s = t;
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            s = t;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    t[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                s = t;
            end
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // Entered and left on a falling edge; leaves the DUT back in IDLE.
    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp,
                           input int hold, input bit busy);
        int n;
        n = 0;
        while (!o_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            chk("ready_timeout", 128'(o_ready), 128'd1);
            return;
        end
        chk("idx_accept", 128'(o_key_idx), 128'd10);
        if (last_acc >= 0) chk("accept_interval", 128'(cyc - last_acc), 128'd12);
        last_acc      = cyc;
        i_valid       = 1'b1;
        i_cypher_text = ct;
        i_ready       = (hold == 0);
        @(negedge clk);
        if (busy) i_cypher_text = ~ct;
        else      i_valid = 1'b0;
        for (int j = 9; j >= 0; j--) begin
            chk("idx_run", 128'(o_key_idx), 128'(j));
            chk("valid_early", 128'(o_valid), 128'd0);
            if (busy) chk("ready_busy", 128'(o_ready), 128'd0);
            if (j == 0) i_valid = 1'b0;
            @(negedge clk);
        end
        chk("valid_rise", 128'(o_valid), 128'd1);
        chk("plain_text", o_plain_text, exp);
        for (int k = 0; k < hold; k++) begin
            chk("bp_valid", 128'(o_valid), 128'd1);
            chk("bp_data", o_plain_text, exp);
            chk("bp_ready", 128'(o_ready), 128'd0);
            @(negedge clk);
        end
        i_ready = 1'b1;
        if (hold > 0) chk("bp_valid_last", 128'(o_valid), 128'd1);
        @(negedge clk);
        chk("ready_after_hs", 128'(o_ready), 128'd1);
        chk("valid_after_hs", 128'(o_valid), 128'd0);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key, pt, ct;
        int vcount;
        rst           = 1'b1;
        i_valid       = 1'b0;
        i_ready       = 1'b1;
        i_cypher_text = '0;
        build_sbox();
        load_key('0);

        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(o_ready), 128'd0);
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_plain", o_plain_text, 128'd0);
        chk("rst_idx", 128'(o_key_idx), 128'd10);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", 128'(o_ready), 128'd1);

        load_key(C1_KEY);
        decrypt(C1_CT, C1_PT, 0, 1'b0);
        load_key(B_KEY);
        decrypt(B_CT, B_PT, 0, 1'b0);

        last_acc = -1;
        load_key(C1_KEY);
        decrypt(C1_CT, C1_PT, 5, 1'b0);

        last_acc = -1;
        load_key(B_KEY);
        decrypt(B_CT, B_PT, 0, 1'b1);
        vcount = 0;
        repeat (15) begin
            if (o_valid) vcount++;
            @(negedge clk);
        end
        chk("busy_no_second", 128'(vcount), 128'd0);

        // Abort by reset at T+5.
        load_key(C1_KEY);
        i_valid       = 1'b1;
        i_cypher_text = C1_CT;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_rst", 128'(o_ready), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 128'(o_ready), 128'd1);
        chk("abort_plain", o_plain_text, 128'd0);
        chk("abort_idx", 128'(o_key_idx), 128'd10);
        vcount = 0;
        repeat (15) begin
            if (o_valid) vcount++;
            @(negedge clk);
        end
        chk("abort_no_valid", 128'(vcount), 128'd0);
        last_acc = -1;
        decrypt(C1_CT, C1_PT, 0, 1'b0);

        last_acc = -1;
        for (int b = 0; b < 20; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_key(key);
            ct = aes_enc(pt);
            decrypt(ct, pt, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_data_path.md
# aes_inv_data_path

Iterative AES-128 inverse-cipher datapath: accepts one 128-bit ciphertext block, runs the FIPS-197 inverse cipher at one round per clock, and returns the plaintext. It is the decryption counterpart of the encryption datapath. It fetches round keys by index from the shared key-schedule store, highest index first, and presents the result through a valid/ready handshake.

## Interface

Parameters:
- RND_SIZE, 128, block and round-key width in bits
- WRD_SIZE, 32, column width for InvMixColumns
- NUM_BLK, 4, columns per state
- NUM_RND, 10, number of AES rounds
- CNT_SIZE, 4, width of the round counter and key index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  ciphertext present
- o_ready  out  1  block can accept a ciphertext
- i_cypher_text  in  RND_SIZE  ciphertext block
- o_key_idx  out  CNT_SIZE  round-key index requested this cycle
- i_rnd_key  in  RND_SIZE  round key for o_key_idx, same cycle (combinational store read)
- o_valid  out  1  plaintext available
- i_ready  in  1  downstream accepts plaintext
- o_plain_text  out  RND_SIZE  plaintext block

## Operation

- Byte order follows FIPS-197. Byte 0 is bits [127:120]. The state is column-major, so column c is bytes 4c..4c+3.
- The FSM has three states: IDLE, RUN, DONE. The round counter rnd_cnt counts down.
- IDLE:
  - o_ready=1 and o_key_idx=NUM_RND.
  - On i_valid: state_reg <= i_cypher_text ^ i_rnd_key, rnd_cnt <= NUM_RND-1, go to RUN.
- RUN:
  - o_key_idx=rnd_cnt.
  - Each cycle: state_reg <= f(state_reg). f is InvShiftRows, then InvSubBytes, then AddRoundKey(i_rnd_key), then InvMixColumns. InvMixColumns is skipped when rnd_cnt==0.
  - If rnd_cnt>0, decrement. If rnd_cnt==0, go to DONE.
- DONE:
  - o_valid=1 and o_plain_text=state_reg (registered, stable).
  - On i_ready, go to IDLE.
  - o_key_idx=NUM_RND.
- GF(2^8) arithmetic:
  - Reduction polynomial is x^8+x^4+x^3+x+1.
  - InvMixColumns uses coefficients {0e,0b,0d,09}, built from xtime chains, with no multipliers.
- The inverse S-box is a combinational 256-entry lookup. There are 16 instances, one per byte.
- i_valid outside IDLE is ignored; no buffering.
- o_key_idx always lies in 0..NUM_RND.

## Timing

- Reset values: o_ready=0 during the reset cycle and 1 from the first cycle after reset; o_valid=0; o_plain_text=0; o_key_idx=NUM_RND; FSM=IDLE.
- Accept at cycle T means i_valid&&o_ready are both high at edge T.
- RUN spans cycles T+1..T+10, with o_key_idx = 9,8,...,0.
- o_valid rises at T+11. Latency is 11 cycles from accept to o_valid.
- o_valid holds, with o_plain_text stable, until i_ready. The handshake completes at the edge where o_valid&&i_ready.
- o_ready returns the cycle after that handshake. Minimum initiation interval is 12 cycles with i_ready tied high.
- i_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE) aborts: no o_valid pulse, FSM=IDLE, state_reg cleared.
- i_rnd_key is sampled only at clock edges. The key store must not change between the o_key_idx request and that edge.

## Test plan

- FIPS-197 C.1 (vector 1):
  - Stimulus: key schedule of 000102030405060708090a0b0c0d0e0f, with idx10 = 13111d7fe3944a17f307a78b4d2b30c5; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; i_ready=1.
  - Response: o_plain_text = 00112233445566778899aabbccddeeff with o_valid at exactly T+11.
- FIPS-197 App. B (vector 2):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Response: plaintext 3243f6a8885a308d313198a2e0370734, and o_key_idx sequence 10,9,...,0 over T..T+10.
- Backpressure:
  - Stimulus: hold i_ready=0 for 5 cycles after o_valid.
  - Response: o_valid and o_plain_text stay stable; o_ready=0 throughout; handshake on i_ready=1; o_ready=1 the next cycle.
- Busy ignore:
  - Stimulus: drive a second ciphertext with i_valid=1 during RUN.
  - Response: result still matches the first vector, and no second output occurs.
- Reset mid-run:
  - Stimulus: assert rst at T+5.
  - Response: o_valid never asserts; o_plain_text=0; o_ready=1 after reset; a following C.1 decrypt completes correctly.
- Back-to-back:
  - Stimulus: 20 random keys and plaintexts encrypted by the reference model, fed with i_ready=1.
  - Response: all 20 plaintexts recovered, and the interval between accepts is 12 cycles.
